uart_rx_fifo: RTL and testbench

- UART receiver (8N1) with a small receive FIFO.
- Sits directly behind the board-level fpga_rx pin inside sm_top and feeds received bytes to the stack-machine core and program loader.
- Core pops bytes with a single-cycle read strobe.
- Error conditions are reported through sticky flags that the core clears.

---
 rtl/uart_rx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with first-word fall-through receive FIFO
//
// clk        system clock
// rst_n      synchronous active-low reset
// fpga_rx    asynchronous serial input, idle high
// rx_rd      pop strobe, one byte removed per asserted cycle
// rx_data    FIFO head byte, valid while rx_empty=0
// rx_empty   FIFO empty
// rx_count   bytes held, 0..2**FIFO_AW
// frame_err  sticky, stop bit sampled low
// overrun    sticky, byte dropped because FIFO was full
// err_clr    clears frame_err and overrun

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fpga_rx,
    input  logic               rx_rd,
    output logic [7:0]         rx_data,
    output logic               rx_empty,
    output logic [FIFO_AW:0]   rx_count,
    output logic               frame_err,
    output logic               overrun,
    input  logic               err_clr
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    state_t          state, state_d;
    logic            rx_meta, rx_s;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      bit_idx, bit_idx_d;
    logic [7:0]      shift, shift_d;
    logic            push, frame_set;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, do_push, do_pop, ovr_set;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                cnt_d = cnt + 1'b1;
                if (cnt == CNT_HALF) begin
                    // Line back high at mid start bit: treat as noise.
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                cnt_d = cnt + 1'b1;
                if (cnt == CNT_FULL) begin
                    shift_d[bit_idx] = rx_s;
                    cnt_d            = '0;
                    bit_idx_d        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                cnt_d = cnt + 1'b1;
                if (cnt == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_BRK;
                    end
                end
            end
            S_BRK: begin
                // Hold off until the line idles so a break is not read as new frames.
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            rx_meta <= fpga_rx;
            rx_s    <= rx_meta;
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
        end
    end

    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    assign full    = (count == DEPTH_C);
    assign do_pop  = rx_rd && (count != '0);
    assign do_push = push && (!full || rx_rd);
    assign ovr_set = push && full && !rx_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set wins over a coincident clear.
            frame_err <= frame_set | (frame_err & ~err_clr);
            overrun   <= ovr_set   | (overrun   & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= shift;
    end

    assign rx_data  = mem[rd_ptr];
    assign rx_empty = (count == '0);
    assign rx_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a byte-level queue model

module tb_uart_rx_fifo;

    localparam int CPB   = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    // start edge -> push edge: 2 sync + 1 idle detect + half bit + 8 data bits + stop bit
    localparam int LAT   = 3 + CPB / 2 + 9 * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fpga_rx = 1'b1;
    logic          rx_rd = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_empty;
    logic [AW:0]   rx_count;
    logic          frame_err;
    logic          overrun;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fpga_rx   (fpga_rx),
        .rx_rd     (rx_rd),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    typedef struct {
        int         cyc;
        logic [7:0] d;
        bit         ok;
    } ev_t;

    ev_t        pend[$];
    logic [7:0] q[$];
    bit         m_fe, m_ov;
    int         cyc = 0;
    int         t_start = 0;
    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 1'b0;
    bit         done = 1'b0;
    int         lat_n;

    ev_t        ev;
    bit         m_acc, m_fes, m_ovs, m_pop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: arriving frames are scheduled events; FIFO is a plain queue.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            pend.delete();
            m_fe = 1'b0;
            m_ov = 1'b0;
        end else begin
            m_pop = rx_rd && (q.size() > 0);
            m_acc = 1'b0;
            m_fes = 1'b0;
            m_ovs = 1'b0;
            if (pend.size() > 0 && pend[0].cyc == cyc) begin
                ev = pend.pop_front();
                if (!ev.ok)                            m_fes = 1'b1;
                else if (q.size() < DEPTH || rx_rd)    m_acc = 1'b1;
                else                                   m_ovs = 1'b1;
            end
            if (m_pop) void'(q.pop_front());
            if (m_acc) q.push_back(ev.d);
            if (err_clr) begin
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            if (m_fes) m_fe = 1'b1;
            if (m_ovs) m_ov = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rx_count", 32'(rx_count), 32'(q.size()));
            chk("rx_empty", 32'(rx_empty), 32'(q.size() == 0));
            chk("frame_err", 32'(frame_err), 32'(m_fe));
            chk("overrun", 32'(overrun), 32'(m_ov));
            if (q.size() > 0) chk("rx_data", 32'(rx_data), 32'(q[0]));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit pop_at_push,
                              input bit rst_mid);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        fpga_rx = 1'b0;
        t_start = cyc;
        pend.push_back('{cyc + LAT, b, stop});
        for (int i = 1; i < 10; i++) begin
            repeat (CPB) @(posedge clk);
            #1;
            fpga_rx = f[i];
            if (rst_mid && i == 5) begin
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        if (pop_at_push) begin
            repeat (CPB - 2) @(posedge clk);
            #1 rx_rd = 1'b1;
            @(posedge clk);
            #1 rx_rd = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            repeat (CPB) @(posedge clk);
            #1;
        end
        if (!stop) begin
            repeat (20) @(posedge clk);
            #1;
        end
        fpga_rx = 1'b1;
    endtask

    task automatic glitch();
        @(posedge clk);
        #1 fpga_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 fpga_rx = 1'b1;
    endtask

    task automatic pulse_rd();
        @(posedge clk);
        #1 rx_rd = 1'b1;
        @(posedge clk);
        #1 rx_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    task automatic read_expect(input logic [7:0] b, input string nm);
        @(negedge clk);
        chk(nm, 32'(rx_data), 32'(b));
        pulse_rd();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_empty", 32'(rx_empty), 32'd1);
        chk("reset_count", 32'(rx_count), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk_en = 1'b1;

        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
            begin
                lat_n = 0;
                @(negedge clk);
                while (rx_empty && lat_n < 300) begin
                    @(negedge clk);
                    lat_n++;
                end
                chk("a5_latency", 32'(cyc - t_start), 32'd79);
            end
        join
        @(negedge clk);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_count", 32'(rx_count), 32'd1);
        chk("a5_flags", 32'({frame_err, overrun}), 32'd0);
        pulse_rd();
        @(negedge clk);
        chk("a5_pop_empty", 32'(rx_empty), 32'd1);
        chk("a5_pop_count", 32'(rx_count), 32'd0);

        glitch();
        idle(100);
        chk("glitch_count", 32'(rx_count), 32'd0);
        chk("glitch_frame_err", 32'(frame_err), 32'd0);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(5);
        @(negedge clk);
        chk("brk_frame_err", 32'(frame_err), 32'd1);
        chk("brk_count", 32'(rx_count), 32'd0);
        pulse_clr();
        @(negedge clk);
        chk("brk_cleared", 32'(frame_err), 32'd0);

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        chk("ovr_count", 32'(rx_count), 32'd4);
        chk("ovr_flag", 32'(overrun), 32'd1);
        read_expect(8'h01, "ovr_rd0");
        read_expect(8'h02, "ovr_rd1");
        read_expect(8'h03, "ovr_rd2");
        read_expect(8'h04, "ovr_rd3");
        @(negedge clk);
        chk("ovr_drained", 32'(rx_empty), 32'd1);
        pulse_clr();

        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        idle(2);
        @(negedge clk);
        chk("fullpop_overrun", 32'(overrun), 32'd0);
        chk("fullpop_count", 32'(rx_count), 32'd4);
        read_expect(8'h02, "fullpop_rd0");
        read_expect(8'h03, "fullpop_rd1");
        read_expect(8'h04, "fullpop_rd2");
        read_expect(8'h55, "fullpop_rd3");
        @(negedge clk);
        chk("fullpop_drained", 32'(rx_empty), 32'd1);

        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        idle(5);
        @(negedge clk);
        chk("rstmid_count", 32'(rx_count), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        chk("rstmid_next_data", 32'(rx_data), 32'h81);
        chk("rstmid_next_count", 32'(rx_count), 32'd1);
        pulse_rd();

        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    if ($urandom % 8 == 0) begin
                        glitch();
                        idle(10);
                    end
                    send_frame(8'($urandom), ($urandom % 6) != 0, 1'b0, 1'b0);
                    idle($urandom_range(4, 10));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    rx_rd   = ($urandom % 3) == 0;
                    err_clr = ($urandom % 20) == 0;
                end
                rx_rd   = 1'b0;
                err_clr = 1'b0;
            end
        join

        idle(100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
